data_mem_bank: RTL and testbench

Parametrised single-port data memory for the CPU datapath. It replaces the fixed 256×16 negedge-write store with a posedge, handshaked memory. The memory has byte-lane write enables, a selectable read latency of 1 or 2 cycles, and a hardware clear sequencer that zero-fills the array after reset or on request. It sits between the load/store stage and the core's data bus.

---
 rtl/mem_pkg.sv | 16 +
 rtl/sp_ram_be.sv | 42 ++++
 rtl/data_mem_bank.sv | 120 ++++++++++++
 tb/tb_data_mem_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory bank: FSM state encodings,
// read-latency legality check and byte-lane count helper.
package mem_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  function automatic bit read_lat_ok(input int unsigned lat);
    return (lat == 32'd1) || (lat == 32'd2);
  endfunction

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port DEPTH x DATA_W array with per-byte-lane write enables and a
// registered read port that holds its value between reads.
module sp_ram_be
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int unsigned LANES = lane_count(DATA_W);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  if ((DATA_W % 32'd8) != 32'd0 || DATA_W == 32'd0) begin : g_bad_width
    $error("sp_ram_be: DATA_W must be a non-zero multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately not reset; only the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_bank.sv
// Handshaked single-port data memory with byte-lane writes, 1- or 2-cycle
// read latency and a zero-fill sequencer that runs after reset or on request.
module data_mem_bank
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_start,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [lane_count(DATA_W)-1:0] req_be,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          busy
);

  localparam int unsigned LANES = lane_count(DATA_W);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("data_mem_bank: READ_LAT must be 1 or 2");
  end

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, busy_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [LANES-1:0]  ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              v1_q;

  // Next state and array port mux: sequencer owns the port while clearing.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = req_addr;
    ram_be    = req_be;
    ram_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = ptr_q;
      ram_be    = '1;
      ram_wdata = '0;
      ptr_d     = ptr_q + ADDR_W'(1);
      if (ptr_q == '1) state_d = ST_IDLE;
    end else begin
      ram_we = req_valid & req_we;
      ram_re = req_valid & ~req_we;
      if (clr_start) begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d == ST_CLEAR);
      v1_q    <= ram_re;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;

  sp_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  if (READ_LAT == 32'd2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    // Second output stage; data only advances with a valid response so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= ram_rdata;
      end
    end

    assign rsp_valid = v2_q;
    assign rsp_rdata = d2_q;
  end else begin : g_lat1
    assign rsp_valid = v1_q;
    assign rsp_rdata = ram_rdata;
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench for data_mem_bank: one instance per read latency, sharing stimulus.
module tb_data_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [1:0]  req_be = '0;
  logic [15:0] req_wdata = '0;

  logic        r1_ready, r1_valid, r1_busy;
  logic [15:0] r1_rdata;
  logic        r2_ready, r2_valid, r2_busy;
  logic [15:0] r2_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_bank #(.DATA_W(16), .ADDR_W(8), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .req_valid(req_valid),
    .req_ready(r1_ready), .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
    .req_wdata(req_wdata), .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .busy(r1_busy)
  );

  data_mem_bank #(.DATA_W(16), .ADDR_W(8), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .req_valid(req_valid),
    .req_ready(r2_ready), .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
    .req_wdata(req_wdata), .rsp_valid(r2_valid), .rsp_rdata(r2_rdata), .busy(r2_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Issues one read and captures the lat-1 response then the lat-2 response.
  task automatic do_read(input logic [7:0] a, output logic v1, output logic [15:0] d1,
                         output logic v2, output logic [15:0] d2);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    v1 = r1_valid; d1 = r1_rdata;
    req_valid = 1'b0;
    tick();
    v2 = r2_valid; d2 = r2_rdata;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(r1_ready && r2_ready) && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic v1, v2;
    logic [15:0] d1, d2;
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({r1_ready, r1_busy, r1_valid, r1_rdata} !== {3'b010, 16'h0}) begin
      failures++;
      $display("FAIL reset_vals_lat1 actual=%b/%b/%b/%h required=0/1/0/0000", r1_ready, r1_busy, r1_valid, r1_rdata);
    end
    checks++;
    if ({r2_ready, r2_busy, r2_valid, r2_rdata} !== {3'b010, 16'h0}) begin
      failures++;
      $display("FAIL reset_vals_lat2 actual=%b/%b/%b/%h required=0/1/0/0000", r2_ready, r2_busy, r2_valid, r2_rdata);
    end
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL reset_clear_len actual=%0d required=256", n);
    end
    checks++;
    if ({r1_busy, r2_busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy_fall actual=%b%b required=00", r1_busy, r2_busy);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a;
      a = (i == 0) ? 8'h00 : (i == 1) ? 8'h7F : 8'hFF;
      do_read(a, v1, d1, v2, d2);
      checks++;
      if ({v1, d1, v2, d2} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
        failures++;
        $display("FAIL cleared_read addr=%h actual=%b/%h %b/%h required=1/0000 1/0000", a, v1, d1, v2, d2);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic v1, v2;
    logic [15:0] d1, d2;
    do_write(8'h0B, 16'h1234, 2'b11);
    do_write(8'h0B, 16'hFFE1, 2'b01);
    do_read(8'h0B, v1, d1, v2, d2);
    checks++;
    if ({v1, d1, v2, d2} !== {1'b1, 16'h12E1, 1'b1, 16'h12E1}) begin
      failures++;
      $display("FAIL lane_merge actual=%b/%h %b/%h required=1/12e1 1/12e1", v1, d1, v2, d2);
    end
    do_write(8'h0B, 16'hFFFF, 2'b00);
    do_read(8'h0B, v1, d1, v2, d2);
    checks++;
    if ({v1, d1, v2, d2} !== {1'b1, 16'h12E1, 1'b1, 16'h12E1}) begin
      failures++;
      $display("FAIL be_zero_noop actual=%b/%h %b/%h required=1/12e1 1/12e1", v1, d1, v2, d2);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [3];
    exp[0] = 16'h0002; exp[1] = 16'h0030; exp[2] = 16'h000F;
    for (int i = 0; i < 3; i++) do_write(8'(i), exp[i], 2'b11);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 3); req_we = 1'b0; req_addr = 8'(i);
      tick();
      checks++;
      if (r1_valid !== (i < 3) || (i < 3 && r1_rdata !== exp[i])) begin
        failures++;
        $display("FAIL b2b_lat1 cyc=%0d actual=%b/%h", i, r1_valid, r1_rdata);
      end
      checks++;
      if (r2_valid !== (i >= 1 && i <= 3) || (i >= 1 && i <= 3 && r2_rdata !== exp[i-1])) begin
        failures++;
        $display("FAIL b2b_lat2 cyc=%0d actual=%b/%h", i, r2_valid, r2_rdata);
      end
    end
    checks++;
    if (r1_rdata !== 16'h000F || r2_rdata !== 16'h000F) begin
      failures++;
      $display("FAIL rdata_hold actual=%h/%h required=000f/000f", r1_rdata, r2_rdata);
    end
  endtask

  task automatic test_raw();
    logic v1, v2;
    logic [15:0] d1, d2;
    do_write(8'h05, 16'hBEEF, 2'b11);
    do_read(8'h05, v1, d1, v2, d2);
    checks++;
    if ({v1, d1, v2, d2} !== {1'b1, 16'hBEEF, 1'b1, 16'hBEEF}) begin
      failures++;
      $display("FAIL read_after_write actual=%b/%h %b/%h required=1/beef 1/beef", v1, d1, v2, d2);
    end
  endtask

  task automatic test_clear();
    logic v1, v2;
    logic [15:0] d1, d2;
    int n;
    do_write(8'h03, 16'hAAAA, 2'b11);
    clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h03;
    tick();
    clr_start = 1'b0; req_valid = 1'b0;
    checks++;
    if ({r1_valid, r1_rdata, r1_ready, r1_busy} !== {1'b1, 16'hAAAA, 2'b01}) begin
      failures++;
      $display("FAIL clr_same_cycle_lat1 actual=%b/%h rdy=%b busy=%b required=1/aaaa rdy=0 busy=1", r1_valid, r1_rdata, r1_ready, r1_busy);
    end
    n = 0;
    while (!(r1_ready && r2_ready) && n < 1000) begin
      clr_start = (n == 50);
      tick();
      if (n == 0) begin
        checks++;
        if ({r2_valid, r2_rdata} !== {1'b1, 16'hAAAA}) begin
          failures++;
          $display("FAIL clr_same_cycle_lat2 actual=%b/%h required=1/aaaa", r2_valid, r2_rdata);
        end
      end
      n++;
    end
    clr_start = 1'b0;
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL clr_len actual=%0d required=256", n);
    end
    do_read(8'h03, v1, d1, v2, d2);
    checks++;
    if ({v1, d1, v2, d2} !== {1'b1, 16'h0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL clr_zeroed actual=%b/%h %b/%h required=1/0000 1/0000", v1, d1, v2, d2);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic v1, v2;
    logic [15:0] d1, d2;
    int n;
    do_write(8'h09, 16'h5A5A, 2'b11);
    do_read(8'h09, v1, d1, v2, d2);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    checks++;
    if ({r1_busy, r1_rdata, r2_rdata} !== {1'b1, 16'h5A5A, 16'h5A5A}) begin
      failures++;
      $display("FAIL pre_reset_state actual=%b/%h/%h required=1/5a5a/5a5a", r1_busy, r1_rdata, r2_rdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r1_ready, r1_busy, r1_valid, r1_rdata, r2_ready, r2_busy, r2_valid, r2_rdata} !==
        {3'b010, 16'h0, 3'b010, 16'h0}) begin
      failures++;
      $display("FAIL mid_clear_reset actual=%b%b%b/%h %b%b%b/%h required=010/0000 010/0000",
               r1_ready, r1_busy, r1_valid, r1_rdata, r2_ready, r2_busy, r2_valid, r2_rdata);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL restart_clear_len actual=%0d required=256", n);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_raw();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
